// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encoding seen by the overlay consumers,
// counter widths and a small helper used for sizing.
package game_pkg;

  // State encoding is fixed by the visibility controller and must not change.
  typedef enum logic [1:0] {
    GS_TITLE    = 2'd0,
    GS_PLAY     = 2'd1,
    GS_GAMEOVER = 2'd2,
    GS_PAUSE    = 2'd3
  } game_state_t;

  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 3;

  // Larger of two integers, used to size the shared frame counter.
  function automatic int maxInt(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/game_state_fsm_rise_detect.sv
// Rising-edge detector with a configurable history reset value, so a level
// already high when reset releases can be treated as "not a new press".
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic rise
);

  logic hist_r;

  // Remember the previous sample of the input level.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hist_r <= RESET_VAL;
    end else begin
      hist_r <= in;
    end
  end

  assign rise = in & ~hist_r;

endmodule

// File: rtl/game_state_fsm.sv
// Master game-flow controller: sequences TITLE -> PLAY -> PAUSE/GAMEOVER,
// tracks lives and level, and pulses levelReset on every entry into PLAY.
import game_pkg::*;

module game_state_fsm #(
  parameter int INIT_LIVES      = 3,
  parameter int MAX_LEVEL       = 3,
  parameter int PAUSE_FRAMES    = 60,
  parameter int GAMEOVER_FRAMES = 120
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               spaceKey,
  input  logic               playerHit,
  input  logic               levelCleared,
  output logic [1:0]         gameState,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic               levelReset,
  output logic               gameWon
);

  // Legacy-style state constants tied to the shared encoding.
  localparam logic [1:0] ST_TITLE    = GS_TITLE;
  localparam logic [1:0] ST_PLAY     = GS_PLAY;
  localparam logic [1:0] ST_GAMEOVER = GS_GAMEOVER;
  localparam logic [1:0] ST_PAUSE    = GS_PAUSE;

  // One counter serves both PAUSE and GAMEOVER, so size it for the longer one.
  localparam int CNT_MAX = maxInt(PAUSE_FRAMES, GAMEOVER_FRAMES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   PAUSE_LAST  = CNT_W'(PAUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   GO_MIN      = CNT_W'(GAMEOVER_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(INIT_LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_FIRST = LEVEL_W'(1);

  logic               spacePress_s;
  logic [1:0]         state_r;
  logic [1:0]         nextState_s;
  logic [LIVES_W-1:0] lives_r;
  logic [LIVES_W-1:0] nextLives_s;
  logic [LEVEL_W-1:0] level_r;
  logic [LEVEL_W-1:0] nextLevel_s;
  logic               won_r;
  logic               nextWon_s;
  logic               levelReset_r;
  logic               enterPlay_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   nextCnt_s;

  // History resets high so a key held through reset is not seen as a press.
  rise_detect #(
    .RESET_VAL(1'b1)
  ) u_spaceRise (
    .clk   (clk),
    .resetN(resetN),
    .in    (spaceKey),
    .rise  (spacePress_s)
  );

  // Next-state, lives, level and win-flag decisions for the current state.
  always_comb begin
    nextState_s = state_r;
    nextLives_s = lives_r;
    nextLevel_s = level_r;
    nextWon_s   = won_r;
    case (state_r)
      ST_TITLE: begin
        if (spacePress_s) begin
          nextState_s = ST_PLAY;
          nextLives_s = LIVES_START;
          nextLevel_s = LEVEL_FIRST;
          nextWon_s   = 1'b0;
        end else begin
          nextState_s = ST_TITLE;
        end
      end
      ST_PLAY: begin
        // levelCleared has priority; a simultaneous hit is dropped.
        if (levelCleared) begin
          if (level_r < LEVEL_LAST) begin
            nextLevel_s = level_r + LEVEL_W'(1);
            nextState_s = ST_PAUSE;
          end else begin
            nextWon_s   = 1'b1;
            nextState_s = ST_GAMEOVER;
          end
        end else if (playerHit) begin
          if (lives_r > LIVES_W'(1)) begin
            nextLives_s = lives_r - LIVES_W'(1);
            nextState_s = ST_PAUSE;
          end else begin
            nextLives_s = LIVES_W'(0);
            nextState_s = ST_GAMEOVER;
          end
        end else begin
          nextState_s = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (startOfFrame && (cnt_r == PAUSE_LAST)) begin
          nextState_s = ST_PLAY;
        end else begin
          nextState_s = ST_PAUSE;
        end
      end
      ST_GAMEOVER: begin
        if (spacePress_s && (cnt_r >= GO_MIN)) begin
          nextState_s = ST_TITLE;
        end else begin
          nextState_s = ST_GAMEOVER;
        end
      end
      default: begin
        nextState_s = ST_TITLE;
      end
    endcase
  end

  // Frame counter: cleared on any state change, saturating frame count otherwise.
  always_comb begin
    nextCnt_s = cnt_r;
    if (nextState_s != state_r) begin
      nextCnt_s = '0;
    end else if (startOfFrame && (cnt_r != CNT_SAT)) begin
      nextCnt_s = cnt_r + CNT_W'(1);
    end else begin
      nextCnt_s = cnt_r;
    end
  end

  assign enterPlay_s = (nextState_s == ST_PLAY) && (state_r != ST_PLAY);

  // Register all game-flow state and outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= ST_TITLE;
      lives_r      <= LIVES_W'(0);
      level_r      <= LEVEL_FIRST;
      won_r        <= 1'b0;
      levelReset_r <= 1'b0;
      cnt_r        <= '0;
    end else begin
      state_r      <= nextState_s;
      lives_r      <= nextLives_s;
      level_r      <= nextLevel_s;
      won_r        <= nextWon_s;
      levelReset_r <= enterPlay_s;
      cnt_r        <= nextCnt_s;
    end
  end

  assign gameState  = state_r;
  assign lives      = lives_r;
  assign level      = level_r;
  assign levelReset = levelReset_r;
  assign gameWon    = won_r;

endmodule

// File: tb/tb_game_state_fsm.sv
// Scoreboard bench for game_state_fsm: stimulus queues hand-computed expected
// snapshots tagged with the cycle they are due; a monitor compares on negedge.
module tb_game_state_fsm;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       spaceKey = 1'b0;
  logic       playerHit = 1'b0;
  logic       levelCleared = 1'b0;
  logic [1:0] gameState;
  logic [2:0] lives;
  logic [2:0] level;
  logic       levelReset;
  logic       gameWon;

  typedef struct {
    string      name;
    int         due;
    logic [1:0] st;
    logic [2:0] lv;
    logic [2:0] lvl;
    logic       lr;
    logic       won;
  } exp_t;

  exp_t q[$];
  int   cycleCnt = 0;
  int   compared = 0;
  int   mismatched = 0;

  game_state_fsm #(
    .INIT_LIVES(3), .MAX_LEVEL(3), .PAUSE_FRAMES(60), .GAMEOVER_FRAMES(120)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .spaceKey(spaceKey),
    .playerHit(playerHit), .levelCleared(levelCleared), .gameState(gameState),
    .lives(lives), .level(level), .levelReset(levelReset), .gameWon(gameWon)
  );

  always #5 clk = ~clk;

  // Cycle index used to tag when each expectation becomes due.
  initial forever begin
    @(posedge clk);
    cycleCnt <= cycleCnt + 1;
  end

  // Monitor: pop due expectations and compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cycleCnt) begin
        e = q.pop_front();
        compared++;
        if ({gameState, lives, level, levelReset, gameWon} !==
            {e.st, e.lv, e.lvl, e.lr, e.won}) begin
          mismatched++;
          $display("FAIL %s: got st=%0d lives=%0d level=%0d lr=%0b won=%0b, expected st=%0d lives=%0d level=%0d lr=%0b won=%0b",
                   e.name, gameState, lives, level, levelReset, gameWon,
                   e.st, e.lv, e.lvl, e.lr, e.won);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input string nm, input int dueAt, input logic [1:0] st,
                      input logic [2:0] lv, input logic [2:0] lvl,
                      input logic lr, input logic won);
    exp_t e;
    e.name = nm; e.due = dueAt; e.st = st; e.lv = lv; e.lvl = lvl; e.lr = lr; e.won = won;
    q.push_back(e);
  endtask

  // Expected state after the next active edge.
  task automatic expectNext(input string nm, input logic [1:0] st, input logic [2:0] lv,
                            input logic [2:0] lvl, input logic lr, input logic won);
    push(nm, cycleCnt + 1, st, lv, lvl, lr, won);
  endtask

  // Expected state at the coming falling edge, before any further active edge.
  task automatic expectNow(input string nm, input logic [1:0] st, input logic [2:0] lv,
                           input logic [2:0] lvl, input logic lr, input logic won);
    push(nm, cycleCnt, st, lv, lvl, lr, won);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1; tick();
      startOfFrame = 1'b0; tick();
    end
  endtask

  task automatic pressSpace(input string nm, input logic [1:0] st, input logic [2:0] lv,
                            input logic [2:0] lvl, input logic lr, input logic won);
    spaceKey = 1'b1; expectNext(nm, st, lv, lvl, lr, won); tick();
    spaceKey = 1'b0; tick();
  endtask

  // Full PAUSE: 59 frames hold, the 60th returns to PLAY with one levelReset.
  task automatic runPause(input string nm, input logic [2:0] lv, input logic [2:0] lvl,
                          input logic won);
    frames(59);
    expectNow({nm, "Hold"}, 2'd3, lv, lvl, 1'b0, won);
    startOfFrame = 1'b1; expectNext(nm, 2'd1, lv, lvl, 1'b1, won); tick();
    startOfFrame = 1'b0; expectNext({nm, "LrEnd"}, 2'd1, lv, lvl, 1'b0, won); tick();
  endtask

  initial begin
    tick(); tick();
    expectNow("reset", 2'd0, 3'd0, 3'd1, 1'b0, 1'b0);
    tick();
    resetN = 1'b1;
    tick();

    // Start a game.
    spaceKey = 1'b1; expectNext("start", 2'd1, 3'd3, 3'd1, 1'b1, 1'b0); tick();
    spaceKey = 1'b0; expectNext("startLrEnd", 2'd1, 3'd3, 3'd1, 1'b0, 1'b0); tick();

    // Hit with lives left -> PAUSE, same level; events in PAUSE ignored.
    playerHit = 1'b1; expectNext("hit", 2'd3, 3'd2, 3'd1, 1'b0, 1'b0); tick();
    levelCleared = 1'b1; spaceKey = 1'b1;
    expectNext("pauseIgnore", 2'd3, 3'd2, 3'd1, 1'b0, 1'b0); tick();
    playerHit = 1'b0; levelCleared = 1'b0; spaceKey = 1'b0; tick();
    runPause("resume", 3'd2, 3'd1, 1'b0);

    // Lose remaining lives -> GAMEOVER without win.
    playerHit = 1'b1; expectNext("hit2", 2'd3, 3'd1, 3'd1, 1'b0, 1'b0); tick();
    playerHit = 1'b0; tick();
    runPause("resume2", 3'd1, 3'd1, 1'b0);
    playerHit = 1'b1; expectNext("lastLife", 2'd2, 3'd0, 3'd1, 1'b0, 1'b0); tick();
    playerHit = 1'b0; tick();

    // Space ignored before GAMEOVER_FRAMES, accepted once reached.
    frames(10);
    pressSpace("earlySpace", 2'd2, 3'd0, 3'd1, 1'b0, 1'b0);
    frames(109);
    pressSpace("space119", 2'd2, 3'd0, 3'd1, 1'b0, 1'b0);
    frames(1);
    pressSpace("toTitle", 2'd0, 3'd0, 3'd1, 1'b0, 1'b0);

    // Clear all three levels.
    pressSpace("start2", 2'd1, 3'd3, 3'd1, 1'b1, 1'b0);
    levelCleared = 1'b1; expectNext("clr1", 2'd3, 3'd3, 3'd2, 1'b0, 1'b0); tick();
    levelCleared = 1'b0; tick();
    runPause("lvl2", 3'd3, 3'd2, 1'b0);
    spaceKey = 1'b1; expectNext("playSpaceIgn", 2'd1, 3'd3, 3'd2, 1'b0, 1'b0); tick();
    spaceKey = 1'b0; tick();
    levelCleared = 1'b1; expectNext("clr2", 2'd3, 3'd3, 3'd3, 1'b0, 1'b0); tick();
    levelCleared = 1'b0; tick();
    runPause("lvl3", 3'd3, 3'd3, 1'b0);
    levelCleared = 1'b1; expectNext("won", 2'd2, 3'd3, 3'd3, 1'b0, 1'b1); tick();
    levelCleared = 1'b0; tick();
    frames(120);
    pressSpace("titleWon", 2'd0, 3'd3, 3'd3, 1'b0, 1'b1);
    pressSpace("restart", 2'd1, 3'd3, 3'd1, 1'b1, 1'b0);

    // Simultaneous hit and clear: clear wins.
    levelCleared = 1'b1; playerHit = 1'b1;
    expectNext("both", 2'd3, 3'd3, 3'd2, 1'b0, 1'b0); tick();
    levelCleared = 1'b0; playerHit = 1'b0; tick();

    // Reset in PAUSE is immediate; key held through release is not a press.
    resetN = 1'b0; spaceKey = 1'b1;
    expectNow("midReset", 2'd0, 3'd0, 3'd1, 1'b0, 1'b0);
    tick(); tick();
    resetN = 1'b1;
    expectNext("afterRelease", 2'd0, 3'd0, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) tick();
    expectNow("heldSpace", 2'd0, 3'd0, 3'd1, 1'b0, 1'b0);
    tick();
    spaceKey = 1'b0; tick();
    pressSpace("pressAfterHeld", 2'd1, 3'd3, 3'd1, 1'b1, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/game_state_fsm.md
Name: game_state_fsm

Overview:
- Master game-flow controller. Drives the 2-bit gameState consumed by the background/overlay visibility controller and by the object logic.
- Tracks lives and level, and sequences title -> play -> level pause -> game over -> title.
- Issues a one-cycle levelReset pulse so the ball, player and rope blocks re-initialise at each level start.
- Events come from the keyboard decoder (space) and from the collision block (player hit, all balls popped).

Parameters:
INIT_LIVES, 3, lives loaded at game start (1..7)
MAX_LEVEL, 3, last level; clearing it ends the game with gameWon=1 (1..7)
PAUSE_FRAMES, 60, frames spent in PAUSE before (re)starting a level (>=1)
GAMEOVER_FRAMES, 120, minimum frames in GAMEOVER before space is accepted (>=1)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
spaceKey  in  1  space key level, high while held
playerHit  in  1  one-cycle pulse: a ball touched the player
levelCleared  in  1  one-cycle pulse: last ball popped
gameState  out  2  0=TITLE, 1=PLAY, 2=GAMEOVER, 3=PAUSE
lives  out  3  remaining lives
level  out  3  current level, 1-based
levelReset  out  1  one-cycle pulse: re-initialise level objects
gameWon  out  1  high in GAMEOVER when MAX_LEVEL was cleared

Behaviour:
- All outputs are registered. Async reset: gameState=TITLE(0), lives=0, level=1, levelReset=0, gameWon=0, frame counter=0, space history=1.
- Space history resets to 1 so that a key already held at reset does not act as a press.
- spacePress = spaceKey & ~spaceKey_d1 (rising edge); a held key produces one press only.
- Frame counter: width $clog2(max(PAUSE_FRAMES,GAMEOVER_FRAMES)+1). Cleared on every state change. Increments on startOfFrame and saturates at its maximum.
- TITLE:
  - On spacePress: lives=INIT_LIVES, level=1, gameWon=0, next state PLAY.
- PLAY:
  - levelCleared with level<MAX_LEVEL: level+1, next state PAUSE.
  - levelCleared with level==MAX_LEVEL: gameWon=1, next state GAMEOVER.
  - playerHit with lives>1: lives-1, level unchanged (retry the same level), next state PAUSE.
  - playerHit with lives==1: lives=0, next state GAMEOVER.
  - levelCleared and playerHit in the same cycle: levelCleared wins and playerHit is dropped.
  - spaceKey is ignored.
- PAUSE (gameState=3; the consumer shows no overlay):
  - playerHit, levelCleared and spaceKey are ignored.
  - When startOfFrame arrives with counter==PAUSE_FRAMES-1: next state PLAY.
- GAMEOVER:
  - playerHit and levelCleared are ignored.
  - spacePress is ignored while counter<GAMEOVER_FRAMES.
  - Once the counter has reached GAMEOVER_FRAMES, spacePress: next state TITLE. gameWon is kept until the next TITLE->PLAY transition.
- Every transition into PLAY (from TITLE or PAUSE) sets levelReset=1 for exactly the first cycle in which gameState reads 1. levelReset is low at all other times.
- Latency: 1 clock from the qualifying input edge to the updated gameState/lives/level.
- State encoding is fixed by the consumer and must not be re-encoded. The FSM must never produce an illegal state.
- A reset asserted mid-game returns to TITLE immediately. levelReset is not pulsed by reset.

Decomposition:
- Shared package game_pkg holds:
  - typedef enum logic[1:0] game_state_t {GS_TITLE=0, GS_PLAY=1, GS_GAMEOVER=2, GS_PAUSE=3}
  - LIVES_W=3 and LEVEL_W=3
  - The visibility controller imports this same typedef.
- One natural sub-module: rise_detect (clk, resetN, in, rise; reset value of the history bit is a parameter). Use it for spaceKey.

Test Plan:
- Reset, then a spaceKey pulse -> next cycle gameState=1, lives=3, level=1, and levelReset high for exactly 1 cycle.
- In PLAY, playerHit -> gameState=3, lives=2, level=1. After 60 startOfFrame pulses -> gameState=1 with one levelReset pulse.
- lives=1 in PLAY, playerHit -> gameState=2, lives=0, gameWon=0. Space pressed after 10 frames is ignored; space pressed after 120 frames -> gameState=0.
- Clear levels 1, 2 and 3 in sequence -> level steps to 2 then 3, each via PAUSE. After the third levelCleared -> gameState=2, gameWon=1, level=3.
- playerHit and levelCleared in the same cycle at level 1, lives 3 -> level=2, lives=3, gameState=3.
- spaceKey held high through reset release and for 200 cycles -> gameState stays 0. Release then press -> gameState=1. Reset asserted while in PAUSE -> gameState=0 immediately, lives=0, level=1.
